// File: rtl/core_pkg.sv
// Shared types and constants for the operand-forwarding / load-use hazard logic.
// Record rd is stored zero-extended to HZ_RD_W so one type serves any ADDR_W up to that width.
package core_pkg;

    localparam int HZ_RD_W = 8;
    localparam int FWD_RF = 0;
    localparam logic [HZ_RD_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic               valid;
        logic [HZ_RD_W-1:0] rd;
        logic               regwrite;
        logic               memread;
    } hz_rec_t;

    // A record that will actually write a value somebody can consume (x0 never counts).
    function automatic logic productive(hz_rec_t rec);
        return rec.valid & rec.regwrite & (rec.rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority encoder for one EX source operand: picks the nearest later stage
// whose record produces the register this operand reads.
module fwd_match
    import core_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int FWD_DEPTH = 2,
    localparam int SEL_W = $clog2(FWD_DEPTH + 1)
) (
    input  logic [ADDR_W-1:0]  rs,
    input  logic               used,
    input  hz_rec_t [FWD_DEPTH:0] chain,
    output logic [SEL_W-1:0]   sel
);

    logic chain_unused;

    // Scan from the oldest stage down so the nearest match overwrites older ones.
    always_comb begin
        sel = SEL_W'(FWD_RF);
        if (chain[0].valid && used) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (productive(chain[k]) && (chain[k].rd == HZ_RD_W'(rs))) begin
                    sel = SEL_W'(k);
                end
            end
        end
    end

    // Fields of the chain this matcher never reads.
    always_comb begin
        chain_unused = ^{chain[0].rd, chain[0].regwrite, chain[0].memread};
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            chain_unused = chain_unused ^ chain[k].memread;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selects and ID-stage load-use stall, driven from a private
// shadow chain of destination records (EX, EX+1 .. EX+FWD_DEPTH).
module fwd_hazard_unit
    import core_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int NUM_SRC = 2,
    parameter int FWD_DEPTH = 2,
    localparam int SEL_W = $clog2(FWD_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [ADDR_W-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_memread,
    input  logic                      hold,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel
);

    hz_rec_t [FWD_DEPTH:0]            entry;
    logic [NUM_SRC-1:0][ADDR_W-1:0]   ex_rs;
    logic [NUM_SRC-1:0]               ex_used;
    hz_rec_t                          id_rec;
    logic [NUM_SRC-1:0]               use_hit;
    logic                             capture;

    always_comb begin
        id_rec.valid    = 1'b1;
        id_rec.rd       = HZ_RD_W'(id_rd);
        id_rec.regwrite = id_regwrite;
        id_rec.memread  = id_memread;
    end

    always_comb begin
        use_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            use_hit[i] = id_rs_used[i] && (HZ_RD_W'(id_rs[i*ADDR_W +: ADDR_W]) == entry[0].rd);
        end
    end

    // A load in EX cannot feed the instruction behind it; flush overrides the request.
    assign stall   = id_valid & ~flush & entry[0].memread & productive(entry[0]) & (|use_hit);
    assign capture = id_valid & ~stall & ~flush;

    // ID -> EX -> EX+1 .. EX+FWD_DEPTH record chain
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            entry   <= '0;
            ex_used <= '0;
        end else if (!hold) begin
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                entry[k] <= entry[k-1];
            end
            entry[0] <= capture ? id_rec : '0;
            ex_used  <= capture ? id_rs_used : '0;
        end
    end

    // Operand addresses are only meaningful while ex_used is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!hold) begin
            ex_rs <= id_rs;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
        fwd_match #(
            .ADDR_W   (ADDR_W),
            .FWD_DEPTH(FWD_DEPTH)
        ) u_match (
            .rs   (ex_rs[i]),
            .used (ex_used[i]),
            .chain(entry),
            .sel  (fwd_sel[i*SEL_W +: SEL_W])
        );
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed instruction table, async-reset sequence,
// then random traffic against an instruction-history reference model.
module tb_fwd_hazard_unit;

    localparam int ADDR_W = 5;
    localparam int NUM_SRC = 2;
    localparam int FWD_DEPTH = 2;
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    logic                      clk;
    logic                      arst;
    logic                      id_valid;
    logic [NUM_SRC*ADDR_W-1:0] id_rs;
    logic [NUM_SRC-1:0]        id_rs_used;
    logic [ADDR_W-1:0]         id_rd;
    logic                      id_regwrite;
    logic                      id_memread;
    logic                      hold;
    logic                      flush;
    logic                      stall;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;

    int n_chk = 0;
    int n_fail = 0;

    fwd_hazard_unit #(
        .ADDR_W   (ADDR_W),
        .NUM_SRC  (NUM_SRC),
        .FWD_DEPTH(FWD_DEPTH)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rs_used (id_rs_used),
        .id_rd      (id_rd),
        .id_regwrite(id_regwrite),
        .id_memread (id_memread),
        .hold       (hold),
        .flush      (flush),
        .stall      (stall),
        .fwd_sel    (fwd_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: history of instructions that entered EX, newest first.
    typedef struct {
        bit                             valid;
        int                             rd;
        bit                             rw;
        bit                             mr;
        logic [NUM_SRC-1:0][ADDR_W-1:0] rs;
        logic [NUM_SRC-1:0]             used;
    } ins_t;

    ins_t hist[$];

    function automatic ins_t bubble();
        ins_t b;
        b.valid = 0; b.rd = 0; b.rw = 0; b.mr = 0; b.rs = '0; b.used = '0;
        return b;
    endfunction

    function automatic bit m_prod(ins_t x);
        return x.valid && x.rw && (x.rd != 0);
    endfunction

    function automatic int m_fwd(int i);
        if (!hist[0].valid || !hist[0].used[i]) return 0;
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            if (m_prod(hist[k]) && hist[k].rd == int'(hist[0].rs[i])) return k;
        end
        return 0;
    endfunction

    function automatic bit m_stall();
        if (!id_valid || flush || !hist[0].mr || !m_prod(hist[0])) return 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i] && int'(id_rs[i*ADDR_W +: ADDR_W]) == hist[0].rd) return 1;
        end
        return 0;
    endfunction

    task automatic m_reset();
        hist.delete();
        for (int k = 0; k <= FWD_DEPTH; k++) hist.push_back(bubble());
    endtask

    task automatic m_advance(input bit st);
        ins_t n;
        if (!hold) begin
            n = bubble();
            if (id_valid && !st && !flush) begin
                n.valid = 1; n.rd = int'(id_rd); n.rw = id_regwrite; n.mr = id_memread;
                n.rs = id_rs; n.used = id_rs_used;
            end
            hist.push_front(n);
            void'(hist.pop_back());
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                          input logic [1:0] used, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic hd, input logic fl);
        id_valid = v; id_rs = {rs1, rs0}; id_rs_used = used; id_rd = rd;
        id_regwrite = rw; id_memread = mr; hold = hd; flush = fl;
    endtask

    // One cycle checked against the model; enters and leaves at a falling edge.
    task automatic model_cycle(input string tag);
        bit st;
        #1;
        st = m_stall();
        chk($sformatf("%s stall", tag), stall, st);
        for (int i = 0; i < NUM_SRC; i++)
            chk($sformatf("%s fwd_sel[%0d]", tag, i), fwd_sel[i*SEL_W +: SEL_W], m_fwd(i));
        @(posedge clk);
        m_advance(st);
        @(negedge clk);
    endtask

    typedef struct {
        logic       vld;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       hd;
        logic       fl;
        logic       es;
        logic [1:0] ef0;
        logic [1:0] ef1;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic hd, input logic fl,
                       input logic es, input logic [1:0] ef0, input logic [1:0] ef1);
        vec_t r;
        r.vld = v; r.rs0 = rs0; r.rs1 = rs1; r.used = used; r.rd = rd; r.rw = rw;
        r.mr = mr; r.hd = hd; r.fl = fl; r.es = es; r.ef0 = ef0; r.ef1 = ef1;
        tbl.push_back(r);
    endtask

    task automatic nop(input logic hd, input logic [1:0] ef0, input logic [1:0] ef1);
        row(0, 0, 0, 2'b00, 0, 0, 0, hd, 0, 0, ef0, ef1);
    endtask

    initial begin
        bit st;

        // add x5; add x6,x5,x7 -> MEM forward on operand 0
        row(1, 1, 2, 2'b11, 5, 1, 0, 0, 0, 0, 0, 0);
        row(1, 5, 7, 2'b11, 6, 1, 0, 0, 0, 0, 0, 0);
        nop(0, 1, 0);
        // add x5; nop; sub x8,x9,x5 -> WB forward on operand 1
        row(1, 1, 2, 2'b11, 5, 1, 0, 0, 0, 0, 0, 0);
        nop(0, 0, 0);
        row(1, 9, 5, 2'b11, 8, 1, 0, 0, 0, 0, 0, 0);
        nop(0, 0, 2);
        // add x5; addi x5,x5; add x10,x5,x5 -> nearest producer wins
        row(1, 1, 2, 2'b11, 5, 1, 0, 0, 0, 0, 0, 0);
        row(1, 5, 5, 2'b01, 5, 1, 0, 0, 0, 0, 0, 0);
        row(1, 5, 5, 2'b11, 10, 1, 0, 0, 0, 0, 1, 0);
        nop(0, 1, 1);
        // lw x5; add x11,x5,x3 -> one stall, then forward from WB
        row(1, 1, 0, 2'b01, 5, 1, 1, 0, 0, 0, 0, 0);
        row(1, 5, 3, 2'b11, 11, 1, 0, 0, 0, 1, 0, 0);
        row(1, 5, 3, 2'b11, 11, 1, 0, 0, 0, 0, 0, 0);
        nop(0, 2, 0);
        // lw x0; add x12,x0,x0 -> no stall, no forward
        row(1, 1, 0, 2'b01, 0, 1, 1, 0, 0, 0, 0, 0);
        row(1, 0, 0, 2'b11, 12, 1, 0, 0, 0, 0, 0, 0);
        nop(0, 0, 0);
        // lw x5; consumer flushed -> no stall, bubble
        row(1, 1, 0, 2'b01, 5, 1, 1, 0, 0, 0, 0, 0);
        row(1, 5, 5, 2'b11, 13, 1, 0, 0, 1, 0, 0, 0);
        nop(0, 0, 0);
        // add x7; add x14,x7,x7; hold three cycles -> selects frozen
        row(1, 1, 2, 2'b11, 7, 1, 0, 0, 0, 0, 0, 0);
        row(1, 7, 7, 2'b11, 14, 1, 0, 0, 0, 0, 0, 0);
        nop(1, 1, 1);
        nop(1, 1, 1);
        nop(1, 1, 1);
        nop(0, 1, 1);
        nop(0, 0, 0);
        // lw x9; add x15,x3,x9 with hold during the stall
        row(1, 1, 0, 2'b01, 9, 1, 1, 0, 0, 0, 0, 0);
        row(1, 3, 9, 2'b11, 15, 1, 0, 1, 0, 1, 0, 0);
        row(1, 3, 9, 2'b11, 15, 1, 0, 0, 0, 1, 0, 0);
        row(1, 3, 9, 2'b11, 15, 1, 0, 0, 0, 0, 0, 0);
        nop(0, 0, 2);

        // Reset with a would-be hazard presented on the ID inputs.
        arst = 1'b1;
        set_in(1, 5, 5, 2'b11, 5, 1, 1, 0, 0);
        #12;
        chk("reset stall", stall, 0);
        chk("reset fwd_sel", fwd_sel, 0);
        @(negedge clk);
        arst = 1'b0;
        m_reset();

        foreach (tbl[n]) begin
            set_in(tbl[n].vld, tbl[n].rs0, tbl[n].rs1, tbl[n].used, tbl[n].rd,
                   tbl[n].rw, tbl[n].mr, tbl[n].hd, tbl[n].fl);
            #1;
            chk($sformatf("row%0d stall", n), stall, tbl[n].es);
            chk($sformatf("row%0d fwd_sel[0]", n), fwd_sel[0 +: SEL_W], tbl[n].ef0);
            chk($sformatf("row%0d fwd_sel[1]", n), fwd_sel[SEL_W +: SEL_W], tbl[n].ef1);
            st = m_stall();
            @(posedge clk);
            m_advance(st);
            @(negedge clk);
        end

        // Async reset mid-stream while a forward and a stall are both active.
        set_in(1, 1, 2, 2'b11, 5, 1, 0, 0, 0);
        model_cycle("ar0");
        set_in(1, 5, 0, 2'b01, 6, 1, 1, 0, 0);
        model_cycle("ar1");
        set_in(1, 6, 0, 2'b11, 7, 1, 0, 0, 0);
        #1;
        chk("pre-reset stall", stall, 1);
        chk("pre-reset fwd_sel[0]", fwd_sel[0 +: SEL_W], 1);
        arst = 1'b1;
        #1;
        chk("async reset stall", stall, 0);
        chk("async reset fwd_sel", fwd_sel, 0);
        @(negedge clk);
        arst = 1'b0;
        m_reset();
        #1;
        chk("post-reset stall", stall, 0);
        chk("post-reset fwd_sel", fwd_sel, 0);
        @(negedge clk);

        // Random traffic over a small register window to provoke matches.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                arst = 1'b1;
                #2;
                chk("rand reset stall", stall, 0);
                chk("rand reset fwd_sel", fwd_sel, 0);
                @(negedge clk);
                arst = 1'b0;
                m_reset();
            end
            set_in($urandom_range(0, 9) < 8,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                   $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
                   $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
            model_cycle($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
